// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, reads imem combinationally each cycle and
// buffers {word, pc} pairs in a small FIFO presented to decode under a valid/ready handshake.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    output logic        inst_valid,
    output logic [15:0] inst,
    output logic [15:0] inst_pc,
    input  logic        dec_ready,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt_req,
    output logic        halted
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    typedef enum logic {
        RUN,
        HALT
    } mode_t;

    mode_t         mode;
    logic [15:0]   fetch_pc;
    logic [AW:0]   count;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [15:0]   ent_inst [DEPTH];
    logic [15:0]   ent_pc   [DEPTH];

    logic enq;
    logic deq;

    assign imem_addr  = fetch_pc;
    assign inst       = ent_inst[rd_ptr];
    assign inst_pc    = ent_pc[rd_ptr];
    // Head is hidden during a redirect so decode never consumes a word about to be flushed.
    assign inst_valid = (count != '0) && !redirect;
    assign halted     = (mode == HALT) && (count == '0);

    assign deq = inst_valid && dec_ready;
    assign enq = (mode == RUN) && !redirect && !halt_req && ((count < FULL) || deq);

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            mode     <= RUN;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            mode     <= RUN;
        end else begin
            if (enq) begin
                wr_ptr   <= wr_ptr + AW'(1);
                fetch_pc <= fetch_pc + 16'd1;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW + 1)'(enq) - (AW + 1)'(deq);
            if (halt_req) begin
                mode <= HALT;
            end
        end
    end

    // Payload storage needs no reset: entries are only observed once count marks them valid.
    always_ff @(posedge clk) begin
        if (enq) begin
            ent_inst[wr_ptr] <= imem_rdata;
            ent_pc[wr_ptr]   <= fetch_pc;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic against a
// queue-based reference model of the fetch/decode handshake.
module tb_fetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [15:0] RPC   = 16'h0000;

    logic        clk;
    logic        reset;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        inst_valid;
    logic [15:0] inst;
    logic [15:0] inst_pc;
    logic        dec_ready;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt_req;
    logic        halted;

    fetch_queue #(
        .DEPTH   (DEPTH),
        .RESET_PC(RPC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .dec_ready  (dec_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .halt_req   (halt_req),
        .halted     (halted)
    );

    logic [15:0] mem [65536];
    assign imem_rdata = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int check_cnt = 0;
    int cyc       = 0;

    // Reference model: a plain FIFO of {word, pc}, the next PC to fetch and a halted flag.
    typedef struct packed {
        logic [15:0] w;
        logic [15:0] pc;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] m_pc;
    logic        m_halt;

    task automatic model_step();
        bit take;
        bit put;
        if (!reset) begin
            mq.delete();
            m_pc   = RPC;
            m_halt = 1'b0;
        end else if (redirect) begin
            mq.delete();
            m_pc   = redirect_pc;
            m_halt = 1'b0;
        end else begin
            take = (mq.size() != 0) && dec_ready;
            put  = !m_halt && !halt_req && ((mq.size() < DEPTH) || take);
            if (take) void'(mq.pop_front());
            if (put) begin
                mq.push_back('{w: mem[m_pc], pc: m_pc});
                m_pc = m_pc + 16'd1;
            end
            if (halt_req) m_halt = 1'b1;
        end
    endtask

    function automatic logic [49:0] expv();
        logic        v;
        logic [15:0] w;
        logic [15:0] p;
        v = (mq.size() != 0) && !redirect;
        w = 16'h0;
        p = 16'h0;
        if (v) begin
            w = mq[0].w;
            p = mq[0].pc;
        end
        return {v, w, p, m_pc, m_halt && (mq.size() == 0)};
    endfunction

    function automatic logic [49:0] obsv();
        return {inst_valid, inst_valid ? inst : 16'h0, inst_valid ? inst_pc : 16'h0, imem_addr, halted};
    endfunction

    task automatic setin(input logic rst, input logic red, input logic [15:0] rpc,
                         input logic hr, input logic dr);
        @(negedge clk);
        reset       = rst;
        redirect    = red;
        redirect_pc = rpc;
        halt_req    = hr;
        dec_ready   = dr;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        cyc++;
    endtask

    task automatic test_reset();
        setin(0, 0, 16'h0, 0, 1);
        step();
        setin(0, 0, 16'h0, 0, 1);
        step();
        setin(0, 0, 16'h0, 0, 1);
        check_cnt++;
        if ({inst_valid, halted, imem_addr} !== {1'b0, 1'b0, RPC})
            $display("FAIL reset_state valid/halted/addr got=%b/%b/%h exp=0/0/%h",
                     inst_valid, halted, imem_addr, RPC);
        else pass_cnt++;
    endtask

    task automatic test_stream();
        setin(0, 0, 16'h0, 0, 1);
        step();
        for (int i = 0; i < 8; i++) begin
            setin(1, 0, 16'h0, 0, 1);
            check_cnt++;
            if (obsv() !== expv())
                $display("FAIL stream_model cyc=%0d got=%h exp=%h", cyc, obsv(), expv());
            else pass_cnt++;
            if (i >= 1) begin
                check_cnt++;
                if ({inst_valid, inst, inst_pc} !== {1'b1, mem[i-1], 16'(i - 1)})
                    $display("FAIL stream_order i=%0d got=%b/%h/%h exp=1/%h/%h",
                             i, inst_valid, inst, inst_pc, mem[i-1], 16'(i - 1));
                else pass_cnt++;
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        setin(0, 0, 16'h0, 0, 0);
        step();
        for (int i = 0; i < 10; i++) begin
            setin(1, 0, 16'h0, 0, 0);
            check_cnt++;
            if (obsv() !== expv())
                $display("FAIL stall_model cyc=%0d got=%h exp=%h", cyc, obsv(), expv());
            else pass_cnt++;
            step();
        end
        for (int k = 0; k < 8; k++) begin
            setin(1, 0, 16'h0, 0, 1);
            check_cnt++;
            if ({inst_valid, inst, inst_pc, imem_addr} !== {1'b1, mem[k], 16'(k), 16'(DEPTH + k)})
                $display("FAIL full_stream k=%0d got=%b/%h/%h/%h exp=1/%h/%h/%h",
                         k, inst_valid, inst, inst_pc, imem_addr, mem[k], 16'(k), 16'(DEPTH + k));
            else pass_cnt++;
            step();
        end
    endtask

    task automatic test_redirect();
        setin(0, 0, 16'h0, 0, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            setin(1, 0, 16'h0, 0, 0);
            step();
        end
        setin(1, 1, 16'h0040, 0, 1);
        check_cnt++;
        if (inst_valid !== 1'b0) $display("FAIL redirect_cycle_valid got=%b exp=0", inst_valid);
        else pass_cnt++;
        step();
        setin(1, 0, 16'h0, 0, 0);
        check_cnt++;
        if ({inst_valid, imem_addr} !== {1'b0, 16'h0040})
            $display("FAIL redirect_flush got=%b/%h exp=0/0040", inst_valid, imem_addr);
        else pass_cnt++;
        step();
        setin(1, 0, 16'h0, 0, 0);
        check_cnt++;
        if ({inst_valid, inst, inst_pc} !== {1'b1, mem[16'h40], 16'h0040})
            $display("FAIL redirect_target got=%b/%h/%h exp=1/%h/0040",
                     inst_valid, inst, inst_pc, mem[16'h40]);
        else pass_cnt++;
        step();
    endtask

    task automatic test_halt();
        setin(0, 0, 16'h0, 0, 0);
        step();
        for (int i = 0; i < 2; i++) begin
            setin(1, 0, 16'h0, 0, 0);
            step();
        end
        setin(1, 0, 16'h0, 1, 1);
        check_cnt++;
        if ({inst_valid, inst_pc, halted} !== {1'b1, 16'h0000, 1'b0})
            $display("FAIL halt_drain0 got=%b/%h/%b exp=1/0000/0", inst_valid, inst_pc, halted);
        else pass_cnt++;
        step();
        setin(1, 0, 16'h0, 0, 1);
        check_cnt++;
        if ({inst_valid, inst_pc, halted} !== {1'b1, 16'h0001, 1'b0})
            $display("FAIL halt_drain1 got=%b/%h/%b exp=1/0001/0", inst_valid, inst_pc, halted);
        else pass_cnt++;
        step();
        for (int i = 0; i < 4; i++) begin
            setin(1, 0, 16'h0, 0, 1);
            check_cnt++;
            if ({inst_valid, halted, imem_addr} !== {1'b0, 1'b1, 16'h0002})
                $display("FAIL halted_hold i=%0d got=%b/%b/%h exp=0/1/0002",
                         i, inst_valid, halted, imem_addr);
            else pass_cnt++;
            step();
        end
        setin(1, 1, 16'h0010, 0, 1);
        step();
        setin(1, 0, 16'h0, 0, 1);
        check_cnt++;
        if ({halted, imem_addr} !== {1'b0, 16'h0010})
            $display("FAIL halt_exit got=%b/%h exp=0/0010", halted, imem_addr);
        else pass_cnt++;
        step();
        setin(1, 0, 16'h0, 0, 1);
        check_cnt++;
        if ({inst_valid, inst, inst_pc} !== {1'b1, mem[16'h10], 16'h0010})
            $display("FAIL halt_resume got=%b/%h/%h exp=1/%h/0010", inst_valid, inst, inst_pc, mem[16'h10]);
        else pass_cnt++;
        step();
    endtask

    task automatic test_wrap_and_midreset();
        logic [15:0] exp_pc;
        setin(1, 1, 16'hFFFE, 0, 1);
        step();
        setin(1, 0, 16'h0, 0, 1);
        step();
        exp_pc = 16'hFFFE;
        for (int j = 0; j < 3; j++) begin
            setin(1, 0, 16'h0, 0, 1);
            check_cnt++;
            if ({inst_valid, inst_pc, inst} !== {1'b1, exp_pc, mem[exp_pc]})
                $display("FAIL pc_wrap j=%0d got=%b/%h/%h exp=1/%h/%h",
                         j, inst_valid, inst_pc, inst, exp_pc, mem[exp_pc]);
            else pass_cnt++;
            exp_pc = exp_pc + 16'd1;
            step();
        end
        for (int i = 0; i < 6; i++) begin
            setin(1, 0, 16'h0, 0, 0);
            step();
        end
        setin(0, 0, 16'h0, 0, 0);
        step();
        setin(1, 0, 16'h0, 0, 0);
        check_cnt++;
        if ({inst_valid, imem_addr, halted} !== {1'b0, RPC, 1'b0})
            $display("FAIL midstream_reset got=%b/%h/%b exp=0/%h/0", inst_valid, imem_addr, halted, RPC);
        else pass_cnt++;
        step();
    endtask

    task automatic test_random();
        logic        rr;
        logic        rd;
        logic        rh;
        logic        rs;
        logic [15:0] rp;
        for (int i = 0; i < 600; i++) begin
            rs = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            rd = ($urandom_range(0, 99) < 6);
            rh = ($urandom_range(0, 99) < 3);
            rr = ($urandom_range(0, 99) < 60);
            rp = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3)) : 16'($urandom);
            setin(rs, rd, rp, rh, rr);
            check_cnt++;
            if (obsv() !== expv())
                $display("FAIL random_model cyc=%0d got=%h exp=%h", cyc, obsv(), expv());
            else pass_cnt++;
            step();
        end
    endtask

    initial begin
        reset       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0;
        halt_req    = 1'b0;
        dec_ready   = 1'b0;
        m_pc        = RPC;
        m_halt      = 1'b0;
        for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_halt();
        test_wrap_and_midreset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
